// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed at issue into shadow registers and committed when the busy window ends.
module mdu_seq #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       MDUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic {IDLE, RUN} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   hi_sh_q, lo_sh_q;
    logic [2*WIDTH-1:0] res_d;
    logic               load_sh;

    function automatic logic [2*WIDTH-1:0] mul_res(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic             sgn);
        logic signed [2*WIDTH-1:0] ae, be;
        ae = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        be = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        return ae * be;
    endfunction

    // Returns {remainder, quotient}; zero divisor and signed overflow are defined, not trapped.
    function automatic logic [2*WIDTH-1:0] div_res(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic             sgn);
        logic signed [WIDTH-1:0] as, bs, q, r;
        as = a;
        bs = b;
        if (b == '0) begin
            return {a, {WIDTH{1'b1}}};
        end else if (sgn && a == {1'b1, {(WIDTH-1){1'b0}}} && b == {WIDTH{1'b1}}) begin
            return {{WIDTH{1'b0}}, a};
        end else if (sgn) begin
            q = as / bs;
            r = as % bs;
            return {r, q};
        end else begin
            return {a % b, a / b};
        end
    endfunction

    always_comb begin
        if (MDUOp == OP_MULT || MDUOp == OP_MULTU) begin
            res_d = mul_res(A, B, MDUOp == OP_MULT);
        end else begin
            res_d = div_res(A, B, MDUOp == OP_DIV);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        load_sh = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (MDUOp)
                        OP_MULT, OP_MULTU: begin
                            state_d = RUN;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            load_sh = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = RUN;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            load_sh = 1'b1;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    hi_d    = hi_sh_q;
                    lo_d    = lo_sh_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Shadow result needs no reset: it is only committed from RUN, which reset leaves.
    always_ff @(posedge clk) begin
        if (load_sh) begin
            {hi_sh_q, lo_sh_q} <= res_d;
        end
    end

    assign busy = (state_q == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: vector table through a scoreboard queue, plus hand-written
// sequences for ignored start, back-to-back issue and reset mid-operation.
module tb_mdu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   MDUOp;
    logic [W-1:0] A, B;
    logic         busy;
    logic [W-1:0] HI, LO;

    always #5 clk = ~clk;

    mdu_seq #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
    );

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [W-1:0] a, b, hi, lo;
        int           cyc;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi, lo;
        int           cyc;
    } exp_t;

    vec_t         vecs[15];
    exp_t         sbq[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] m_hi, m_lo;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one op, wait (bounded) for completion, compare against the scoreboard head.
    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input int ecyc);
        exp_t e;
        int   n;
        int   bad_hold;
        e.hi = ehi; e.lo = elo; e.cyc = ecyc;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b1; MDUOp = op; A = a; B = b;
        @(negedge clk);
        start = 1'b0; MDUOp = 3'd0;
        n = 0;
        bad_hold = 0;
        while (busy === 1'b1 && n < 200) begin
            if (HI !== m_hi || LO !== m_lo) bad_hold++;
            n++;
            @(negedge clk);
        end
        e = sbq.pop_front();
        check({name, " busy_cycles"}, 64'(n), 64'(e.cyc));
        check({name, " hold_while_busy"}, 64'(bad_hold), 64'd0);
        check({name, " HI"}, 64'(HI), 64'(e.hi));
        check({name, " LO"}, 64'(LO), 64'(e.lo));
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    initial begin
        vecs[0]  = '{"mult_neg",     3'd1, 32'hffff0000, 32'd4,        32'hffffffff, 32'hfffc0000, 5};
        vecs[1]  = '{"multu",        3'd2, 32'hffff0000, 32'd4,        32'h00000003, 32'hfffc0000, 5};
        vecs[2]  = '{"div_neg",      3'd3, 32'hfffffff9, 32'd2,        32'hffffffff, 32'hfffffffd, 10};
        vecs[3]  = '{"divu",         3'd4, 32'd7,        32'd2,        32'd1,        32'd3,        10};
        vecs[4]  = '{"div_by_zero",  3'd3, 32'd5,        32'd0,        32'd5,        32'hffffffff, 10};
        vecs[5]  = '{"div_overflow", 3'd3, 32'h80000000, 32'hffffffff, 32'h0,        32'h80000000, 10};
        vecs[6]  = '{"divu_by_zero", 3'd4, 32'd5,        32'd0,        32'd5,        32'hffffffff, 10};
        vecs[7]  = '{"mthi",         3'd5, 32'h0000dead, 32'd9,        32'h0000dead, 32'hffffffff, 0};
        vecs[8]  = '{"mtlo",         3'd6, 32'h00001234, 32'd9,        32'h0000dead, 32'h00001234, 0};
        vecs[9]  = '{"op_none",      3'd0, 32'h11111111, 32'd9,        32'h0000dead, 32'h00001234, 0};
        vecs[10] = '{"op_rsvd",      3'd7, 32'h22222222, 32'd9,        32'h0000dead, 32'h00001234, 0};
        vecs[11] = '{"mult_negneg",  3'd1, 32'hfffffffd, 32'hfffffffb, 32'h0,        32'h0000000f, 5};
        vecs[12] = '{"mult_extreme", 3'd1, 32'h7fffffff, 32'h80000000, 32'hc0000000, 32'h80000000, 5};
        vecs[13] = '{"divu_big",     3'd4, 32'hffffffff, 32'd16,       32'h0000000f, 32'h0fffffff, 10};
        vecs[14] = '{"div_negdiv",   3'd3, 32'd7,        32'hfffffffe, 32'd1,        32'hfffffffd, 10};

        reset = 1'b1; start = 1'b0; MDUOp = 3'd0; A = '0; B = '0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset busy", 64'(busy), 64'd0);
        check("reset HI", 64'(HI), 64'd0);
        check("reset LO", 64'(LO), 64'd0);

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].cyc);
        end

        // start with mtlo while busy is ignored; mthi accepted in the first idle cycle
        @(negedge clk);
        start = 1'b1; MDUOp = 3'd1; A = 32'd3; B = 32'd4;
        @(negedge clk);
        start = 1'b0; MDUOp = 3'd0;
        for (int i = 0; i < 5; i++) begin
            check("ignore busy_high", 64'(busy), 64'd1);
            if (i == 1) begin
                start = 1'b1; MDUOp = 3'd6; A = 32'h1234;
            end else begin
                start = 1'b0; MDUOp = 3'd0;
            end
            @(negedge clk);
        end
        check("ignore busy_fall", 64'(busy), 64'd0);
        check("ignore HI", 64'(HI), 64'd0);
        check("ignore LO", 64'(LO), 64'd12);
        start = 1'b1; MDUOp = 3'd5; A = 32'hdead;
        @(negedge clk);
        start = 1'b0; MDUOp = 3'd0;
        check("b2b mthi HI", 64'(HI), 64'h0000dead);
        check("b2b mthi LO", 64'(LO), 64'd12);
        check("b2b mthi busy", 64'(busy), 64'd0);

        // reset on the 3rd busy cycle of a divu
        @(negedge clk);
        start = 1'b1; MDUOp = 3'd4; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0; MDUOp = 3'd0;
        check("rst_mid busy1", 64'(busy), 64'd1);
        @(negedge clk);
        @(negedge clk);
        check("rst_mid busy3", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid busy", 64'(busy), 64'd0);
        check("rst_mid HI", 64'(HI), 64'd0);
        check("rst_mid LO", 64'(LO), 64'd0);
        repeat (12) @(negedge clk);
        check("rst_mid late HI", 64'(HI), 64'd0);
        check("rst_mid late LO", 64'(LO), 64'd0);
        check("rst_mid late busy", 64'(busy), 64'd0);
        m_hi = '0; m_lo = '0;
        run_op("post_rst_multu", 3'd2, 32'd3, 32'd3, 32'd0, 32'd9, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Parametrised multi-cycle multiply/divide unit; successor to the single-cycle combinational ALU.
- Sits beside the ALU in the execute stage.
- Holds architectural HI/LO registers and performs signed/unsigned multiply and divide over a fixed, parametrised number of cycles.
- Asserts busy so the pipeline stall logic can hold dependent mult/div/mfhi/mflo instructions.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- MULT_CYCLES, 5: busy cycles for mult/multu (1 or more).
- DIV_CYCLES, 10: busy cycles for div/divu (1 or more).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  issue strobe; sampled on the rising edge.
- MDUOp  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op).
- A  input  WIDTH  operand A (dividend / multiplicand / mthi-mtlo source).
- B  input  WIDTH  operand B (divisor / multiplier).
- busy  output  1  high while an operation is in flight.
- HI  output  WIDTH  current HI register value (registered).
- LO  output  WIDTH  current LO register value (registered).

Behaviour:
- Reset
  - Synchronous, active-high, on the clk edge.
  - On reset: HI=0, LO=0, busy=0, internal counter=0, pending result discarded.
  - Reset has priority over start.
  - Reset mid-operation cancels the operation: HI/LO read 0 and are never updated by the cancelled result.
- States: IDLE, RUN.
- Issue rule
  - An operation is accepted only at an edge where start=1 and busy=0.
  - start while busy=1 is ignored: no state change, no queueing.
- IDLE, op 1-4 accepted
  - Operands are captured; the result is computed into shadow registers.
  - Counter loads MULT_CYCLES or DIV_CYCLES; state moves to RUN; busy=1 from the next cycle.
- RUN
  - Counter decrements each edge.
  - On the edge where the counter reaches 0: HI/LO are loaded from the shadow registers, busy returns to 0, state moves to IDLE.
  - busy is therefore high for exactly N cycles.
  - The new HI/LO are visible in the first cycle busy=0.
  - A new start may be accepted on the very edge after busy falls; there are no bubble cycles.
- mthi/mtlo (op 5/6), accepted in IDLE
  - HI (or LO) <= A on that same edge.
  - busy stays 0; the other register is unchanged.
- Ops 0 and 7 with start=1: no effect.
- Arithmetic results
  - mult: {HI,LO} = signed(A) x signed(B), full 2*WIDTH product.
  - multu: {HI,LO} = unsigned(A) x unsigned(B), full 2*WIDTH product.
  - div: LO = signed quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - divu: LO = unsigned quotient; HI = unsigned remainder.
- Divide by zero (div or divu with B=0)
  - LO = all ones, HI = A.
  - Takes the full DIV_CYCLES; no exception.
- Signed overflow (div, A = most-negative, B = all ones): LO = A, HI = 0.
- HI/LO change only on reset, on completion of a multiply/divide, or on mthi/mtlo.
- HI/LO are never in a partial state while busy=1: outputs keep their old values until completion.

Test Plan:
- Reset, then signed mult (WIDTH=32, MULT_CYCLES=5)
  - Stimulus: A=32'hffff0000, B=4, MDUOp=1, start for 1 cycle.
  - Response: busy high exactly 5 cycles; then HI=32'hffffffff, LO=32'hfffc0000.
- multu with the same operands (MDUOp=2)
  - Response: HI=32'h00000003, LO=32'hfffc0000 after 5 busy cycles.
- div then divu (DIV_CYCLES=10)
  - div, A=-7 (32'hfffffff9), B=2: after 10 busy cycles LO=32'hfffffffd, HI=32'hffffffff.
  - divu, A=7, B=2: LO=3, HI=1.
- Boundary divides
  - div by zero, A=5, B=0: LO=32'hffffffff, HI=5, busy for 10 cycles.
  - div A=32'h80000000, B=32'hffffffff: LO=32'h80000000, HI=0.
- start ignored while busy; back-to-back issue
  - During mult, pulse start with mtlo A=32'h1234: ignored, LO unaffected.
  - mthi A=32'hdead issued on the first cycle busy=0: HI=32'hdead next cycle, busy stays 0.
- Reset mid-operation
  - Assert reset on the 3rd busy cycle of a divu.
  - Response: next cycle busy=0, HI=LO=0; no late update afterwards; a following multu 3x3 gives LO=9, HI=0.
